// File: rtl/sdram_arbiter_if.sv
// Requester / SDRAM-controller signal bundle for the SDRAM slot arbiter.
// master = requesters plus controller read data, slave = the arbiter.
interface sdram_arbiter_if #(
   parameter int ADDR_W = 25
);
   logic              blank;

   logic              dl_req;
   logic [ADDR_W-1:0] dl_addr;
   logic [7:0]        dl_din;
   logic              dl_ack;

   logic              er_req;
   logic [ADDR_W-1:0] er_addr;
   logic [7:0]        er_din;
   logic              er_ack;

   logic              vdc_req;
   logic              vdc_wr;
   logic [ADDR_W-1:0] vdc_addr;
   logic [7:0]        vdc_din;
   logic              vdc_ack;
   logic [7:0]        vdc_dout;

   logic [ADDR_W-1:0] sdram_addr;
   logic [7:0]        sdram_din;
   logic              sdram_wr;
   logic              sdram_rd;
   logic [7:0]        sdram_dout;

   logic              busy;
   logic [1:0]        grant;

   modport master (
      output blank,
      output dl_req, dl_addr, dl_din,
      output er_req, er_addr, er_din,
      output vdc_req, vdc_wr, vdc_addr, vdc_din,
      output sdram_dout,
      input  dl_ack, er_ack, vdc_ack, vdc_dout,
      input  sdram_addr, sdram_din, sdram_wr, sdram_rd,
      input  busy, grant
   );

   modport slave (
      input  blank,
      input  dl_req, dl_addr, dl_din,
      input  er_req, er_addr, er_din,
      input  vdc_req, vdc_wr, vdc_addr, vdc_din,
      input  sdram_dout,
      output dl_ack, er_ack, vdc_ack, vdc_dout,
      output sdram_addr, sdram_din, sdram_wr, sdram_rd,
      output busy, grant
   );
endinterface

// File: rtl/sdram_arbiter.sv
// Slot sequencer sharing the byte-wide SDRAM port between the ROM
// downloader, the memory eraser and the VDC/CPU path. Each access holds
// one strobe for SLOT_LEN cycles, then acks the owner for one cycle.
// Fixed priority dl > er > vdc, with a starvation guard that promotes a
// pending VDC request after MAX_WAIT lost slots; VDC is locked out while
// blank is high.
module sdram_arbiter #(
   parameter int ADDR_W   = 25,
   parameter int SLOT_LEN = 8,
   parameter int MAX_WAIT = 4
) (
   input logic            F14M,
   input logic            reset_n,
   sdram_arbiter_if.slave bus
);

   localparam int CNT_W  = (SLOT_LEN < 2) ? 1 : $clog2(SLOT_LEN);
   localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SLOT_LEN - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
   typedef enum logic [1:0] {
      ID_NONE = 2'b00,
      ID_DL   = 2'b01,
      ID_ER   = 2'b10,
      ID_VDC  = 2'b11
   } req_id_t;

   state_t            state, state_nx;
   req_id_t           sel, grant_q;
   logic              vdc_elig;
   logic [CNT_W-1:0]  slot_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [ADDR_W-1:0] lat_addr;
   logic [7:0]        lat_din;
   logic              lat_wr;
   logic [7:0]        vdc_dout_q;

   // State register; reset aborts any slot in flight without an ack.
   always_ff @(posedge F14M or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // Arbitration on current request levels and slot sequencing.
   always_comb begin
      state_nx = state;
      sel      = ID_NONE;
      vdc_elig = bus.vdc_req & ~bus.blank;
      case (state)
         S_IDLE: begin
            if (vdc_elig && (wait_cnt >= WAIT_MAX)) sel = ID_VDC;
            else if (bus.dl_req)                    sel = ID_DL;
            else if (bus.er_req)                    sel = ID_ER;
            else if (vdc_elig)                      sel = ID_VDC;
            if (sel != ID_NONE) state_nx = S_ACCESS;
         end
         S_ACCESS: if (slot_cnt == SLOT_LAST) state_nx = S_DONE;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Latch the winner's request at grant; the latches also keep the SDRAM
   // address/data stable between slots.
   always_ff @(posedge F14M or negedge reset_n) begin
      if (!reset_n) begin
         grant_q  <= ID_NONE;
         slot_cnt <= '0;
         lat_addr <= '0;
         lat_din  <= '0;
         lat_wr   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sel != ID_NONE) begin
                  grant_q  <= sel;
                  slot_cnt <= '0;
                  case (sel)
                     ID_DL: begin
                        lat_addr <= bus.dl_addr;
                        lat_din  <= bus.dl_din;
                        lat_wr   <= 1'b1;
                     end
                     ID_ER: begin
                        lat_addr <= bus.er_addr;
                        lat_din  <= bus.er_din;
                        lat_wr   <= 1'b1;
                     end
                     default: begin
                        lat_addr <= bus.vdc_addr;
                        lat_din  <= bus.vdc_din;
                        lat_wr   <= bus.vdc_wr;
                     end
                  endcase
               end
            end
            S_ACCESS: slot_cnt <= slot_cnt + CNT_W'(1);
            S_DONE:   grant_q  <= ID_NONE;
            default:  grant_q  <= ID_NONE;
         endcase
      end
   end

   // VDC starvation counter: counts dl/er slots completed while VDC waits.
   always_ff @(posedge F14M or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= '0;
      end else if (bus.blank) begin
         wait_cnt <= '0;
      end else if (state == S_DONE) begin
         if (grant_q == ID_VDC)
            wait_cnt <= '0;
         else if (bus.vdc_req && (wait_cnt < WAIT_MAX))
            wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   // Capture VDC read data on the last strobe cycle of a VDC read slot.
   always_ff @(posedge F14M or negedge reset_n) begin
      if (!reset_n)
         vdc_dout_q <= '0;
      else if ((state == S_ACCESS) && (slot_cnt == SLOT_LAST) &&
               (grant_q == ID_VDC) && !lat_wr)
         vdc_dout_q <= bus.sdram_dout;
   end

   assign bus.sdram_addr = lat_addr;
   assign bus.sdram_din  = lat_din;
   assign bus.sdram_wr   = (state == S_ACCESS) &  lat_wr;
   assign bus.sdram_rd   = (state == S_ACCESS) & ~lat_wr;
   assign bus.busy       = (state == S_ACCESS);
   assign bus.grant      = grant_q;
   assign bus.dl_ack     = (state == S_DONE) && (grant_q == ID_DL);
   assign bus.er_ack     = (state == S_DONE) && (grant_q == ID_ER);
   assign bus.vdc_ack    = (state == S_DONE) && (grant_q == ID_VDC);
   assign bus.vdc_dout   = vdc_dout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: table of single-requester
// transactions, then hand-written contention, blank lockout and mid-slot
// reset sequences. A negedge monitor scores every slot against a queue of
// expected transactions.
module tb_sdram_arbiter;

   localparam int ADDR_W   = 25;
   localparam int SLOT_LEN = 8;
   localparam int MAX_WAIT = 4;
   localparam int TIMEOUT  = 300;

   logic F14M    = 1'b0;
   logic reset_n = 1'b0;

   always #5 F14M = ~F14M;

   sdram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   sdram_arbiter #(
      .ADDR_W  (ADDR_W),
      .SLOT_LEN(SLOT_LEN),
      .MAX_WAIT(MAX_WAIT)
   ) dut (
      .F14M   (F14M),
      .reset_n(reset_n),
      .bus    (bus)
   );

   typedef struct {
      logic [1:0]        id;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        din;
      logic [7:0]        rdata;
   } exp_t;

   typedef struct {
      logic [1:0]        id;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        din;
      logic [7:0]        rdata;
      bit                mid_change;
      logic [7:0]        exp_dout;
   } vec_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   passes   = 0;
   int   vdc_acks = 0;
   int   idle_strobe_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic ack_of(input logic [1:0] id);
      case (id)
         2'd1:    return bus.dl_ack;
         2'd2:    return bus.er_ack;
         default: return bus.vdc_ack;
      endcase
   endfunction

   task automatic set_req(input logic [1:0] id, input logic v, input logic wr,
                          input logic [ADDR_W-1:0] a, input logic [7:0] d);
      case (id)
         2'd1: begin bus.dl_addr = a; bus.dl_din = d; bus.dl_req = v; end
         2'd2: begin bus.er_addr = a; bus.er_din = d; bus.er_req = v; end
         default: begin
            bus.vdc_addr = a; bus.vdc_din = d; bus.vdc_wr = wr; bus.vdc_req = v;
         end
      endcase
   endtask

   task automatic wait_ack(input logic [1:0] id, output int cycles);
      cycles = 0;
      do begin
         @(negedge F14M);
         cycles++;
      end while (!ack_of(id) && cycles < TIMEOUT);
      chk("ack_seen", ack_of(id), 1);
   endtask

   // Requester that raises req, holds until ack, then idles two cycles.
   task automatic run_req(input logic [1:0] id, input int n,
                          input logic [ADDR_W-1:0] base_addr, input logic [7:0] base_din);
      int cyc;
      for (int k = 0; k < n; k++) begin
         set_req(id, 1'b1, (id != 2'd3), base_addr + ADDR_W'(k), base_din + 8'(k));
         wait_ack(id, cyc);
         set_req(id, 1'b0, (id != 2'd3), base_addr + ADDR_W'(k), base_din + 8'(k));
         @(negedge F14M);
         @(negedge F14M);
      end
   endtask

   function automatic exp_t mk_exp(input logic [1:0] id, input logic [ADDR_W-1:0] a,
                                   input logic [7:0] d, input logic [7:0] rd);
      exp_t e;
      e.id    = id;
      e.wr    = (id != 2'd3);
      e.addr  = a;
      e.din   = d;
      e.rdata = rd;
      return e;
   endfunction

   // Slot monitor: every strobe cycle must match the head of the queue;
   // each ack retires one expected transaction.
   logic [7:0] model_dout  = '0;
   int         slot_cycles = 0;
   bit         slot_ok     = 1'b1;

   always @(negedge F14M) begin
      exp_t       e;
      logic [1:0] aid;
      if (!reset_n) begin
         slot_cycles = 0;
         slot_ok     = 1'b1;
         model_dout  = '0;
      end else begin
         if (!bus.busy && (bus.sdram_wr || bus.sdram_rd)) idle_strobe_err++;
         if (bus.busy) begin
            slot_cycles++;
            if (exp_q.size() == 0) slot_ok = 1'b0;
            else if (bus.sdram_addr !== exp_q[0].addr || bus.sdram_din !== exp_q[0].din ||
                     bus.sdram_wr !== exp_q[0].wr || bus.sdram_rd !== ~exp_q[0].wr ||
                     bus.grant !== exp_q[0].id)
               slot_ok = 1'b0;
         end
         if (bus.dl_ack || bus.er_ack || bus.vdc_ack) begin
            aid = bus.dl_ack ? 2'd1 : (bus.er_ack ? 2'd2 : 2'd3);
            if (bus.vdc_ack) vdc_acks++;
            chk("ack_onehot", 32'(bus.dl_ack) + 32'(bus.er_ack) + 32'(bus.vdc_ack), 1);
            if (exp_q.size() == 0) begin
               chk("ack_unexpected", 32'(aid), 0);
            end else begin
               e = exp_q.pop_front();
               chk("ack_id", 32'(aid), 32'(e.id));
               chk("slot_strobes_bus", 32'(slot_ok), 1);
               chk("slot_len", slot_cycles, SLOT_LEN);
               if (e.id == 2'd3 && !e.wr) model_dout = e.rdata;
               chk("vdc_dout_at_ack", 32'(bus.vdc_dout), 32'(model_dout));
            end
            slot_cycles = 0;
            slot_ok     = 1'b1;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[6];
      logic [1:0]  order[10];
      int          kc[4];
      int          lat;
      int          acks_before;

      bus.blank = 1'b0;
      bus.sdram_dout = '0;
      set_req(2'd1, 1'b0, 1'b1, '0, '0);
      set_req(2'd2, 1'b0, 1'b1, '0, '0);
      set_req(2'd3, 1'b0, 1'b0, '0, '0);

      //          id     wr    addr          din    rdata  mid   exp_dout
      vecs[0] = '{2'd3, 1'b0, 25'h0000100, 8'h00, 8'hA5, 1'b0, 8'hA5};
      vecs[1] = '{2'd1, 1'b1, 25'h0000200, 8'h3C, 8'h00, 1'b1, 8'hA5};
      vecs[2] = '{2'd2, 1'b1, 25'h1FFFFFF, 8'hFF, 8'h00, 1'b0, 8'hA5};
      vecs[3] = '{2'd3, 1'b1, 25'h0000300, 8'h77, 8'hEE, 1'b0, 8'hA5};
      vecs[4] = '{2'd3, 1'b0, 25'h0000301, 8'h00, 8'h12, 1'b0, 8'h12};
      vecs[5] = '{2'd3, 1'b1, 25'h0000000, 8'h00, 8'h99, 1'b1, 8'h12};

      // Reset state
      #2;
      chk("reset_ctl", {bus.busy, bus.grant, bus.dl_ack, bus.er_ack, bus.vdc_ack,
                        bus.sdram_wr, bus.sdram_rd}, 0);
      chk("reset_vdc_dout", 32'(bus.vdc_dout), 0);
      chk("reset_sdram_addr", 32'(bus.sdram_addr), 0);
      chk("reset_sdram_din", 32'(bus.sdram_din), 0);
      @(posedge F14M); #2 reset_n = 1'b1;
      @(negedge F14M);

      // Table: one requester at a time
      for (int i = 0; i < 6; i++) begin
         bus.sdram_dout = vecs[i].rdata;
         exp_q.push_back('{vecs[i].id, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].rdata});
         set_req(vecs[i].id, 1'b1, vecs[i].wr, vecs[i].addr, vecs[i].din);
         lat = 0;
         do begin
            @(negedge F14M);
            lat++;
            if (lat == 3 && vecs[i].mid_change)
               set_req(vecs[i].id, 1'b1, vecs[i].wr, ~vecs[i].addr, ~vecs[i].din);
         end while (!ack_of(vecs[i].id) && lat < TIMEOUT);
         chk("vec_latency", lat, SLOT_LEN + 1);
         chk("vec_vdc_dout", 32'(bus.vdc_dout), 32'(vecs[i].exp_dout));
         set_req(vecs[i].id, 1'b0, vecs[i].wr, vecs[i].addr, vecs[i].din);
         @(negedge F14M);
         chk("vec_after_ack_idle", {bus.grant, bus.busy, bus.dl_ack, bus.er_ack, bus.vdc_ack}, 0);
         chk("vec_addr_hold", 32'(bus.sdram_addr), 32'(vecs[i].addr));
      end

      // Contention: dl/er alternate, VDC promoted after MAX_WAIT lost slots
      order = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
      kc = '{0, 0, 0, 0};
      bus.sdram_dout = 8'h5A;
      for (int i = 0; i < 10; i++) begin
         case (order[i])
            2'd1: exp_q.push_back(mk_exp(2'd1, 25'h1000 + ADDR_W'(kc[1]), 8'h10 + 8'(kc[1]), 8'h5A));
            2'd2: exp_q.push_back(mk_exp(2'd2, 25'h2000 + ADDR_W'(kc[2]), 8'h20 + 8'(kc[2]), 8'h5A));
            default: exp_q.push_back(mk_exp(2'd3, 25'h3000 + ADDR_W'(kc[3]), 8'h30 + 8'(kc[3]), 8'h5A));
         endcase
         kc[order[i]]++;
      end
      fork
         run_req(2'd1, 4, 25'h1000, 8'h10);
         run_req(2'd2, 4, 25'h2000, 8'h20);
         run_req(2'd3, 2, 25'h3000, 8'h30);
      join
      chk("contention_all_retired", exp_q.size(), 0);

      // Blank lockout: VDC held pending across 20 eraser slots
      bus.blank = 1'b1;
      bus.sdram_dout = 8'hC3;
      set_req(2'd3, 1'b1, 1'b0, 25'h4000, 8'h44);
      acks_before = vdc_acks;
      for (int k = 0; k < 20; k++)
         exp_q.push_back(mk_exp(2'd2, 25'h5000 + ADDR_W'(k), 8'h40 + 8'(k), 8'hC3));
      run_req(2'd2, 20, 25'h5000, 8'h40);
      chk("blank_no_vdc_ack", vdc_acks - acks_before, 0);
      exp_q.push_back(mk_exp(2'd3, 25'h4000, 8'h44, 8'hC3));
      bus.blank = 1'b0;
      wait_ack(2'd3, lat);
      chk("unblank_vdc_latency", lat, SLOT_LEN + 1);
      chk("unblank_vdc_dout", 32'(bus.vdc_dout), 32'h0000_00C3);
      set_req(2'd3, 1'b0, 1'b0, 25'h4000, 8'h44);
      @(negedge F14M);

      // Reset in the middle of a downloader slot
      exp_q.push_back(mk_exp(2'd1, 25'h0600, 8'h99, 8'h00));
      set_req(2'd1, 1'b1, 1'b1, 25'h0600, 8'h99);
      repeat (3) @(negedge F14M);
      @(posedge F14M);
      #2 reset_n = 1'b0;
      #1;
      chk("midreset_strobes", {bus.sdram_wr, bus.sdram_rd, bus.busy}, 0);
      chk("midreset_grant", 32'(bus.grant), 0);
      @(negedge F14M);
      chk("midreset_no_ack", {bus.dl_ack, bus.er_ack, bus.vdc_ack}, 0);
      chk("midreset_vdc_dout", 32'(bus.vdc_dout), 0);
      @(posedge F14M);
      #2 reset_n = 1'b1;
      wait_ack(2'd1, lat);
      chk("regrant_latency", lat, SLOT_LEN + 2);
      set_req(2'd1, 1'b0, 1'b1, 25'h0600, 8'h99);
      repeat (2) @(negedge F14M);

      chk("queue_empty", exp_q.size(), 0);
      chk("no_strobe_outside_access", idle_strobe_err, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
